// File: rtl/sprite_compositor.sv
// ---------------------------------------------------------------------------
// sprite_compositor
//
// N-channel monochrome sprite renderer with a sticky collision detector for
// the 640x480 VGA path. For each scan position it decides which enabled
// channels cover the pixel with an opaque bitmap bit. It flags any pixel
// where two or more channels are opaque at once.
//
// Pipeline (the address is presented during cycle t):
//   edge t+1 : per-channel hit / row / column / flip registered (stage 1),
//              frame_done registered
//   edge t+2 : bitmap read, layer / pixel registered (stage 2)
//   edge t+3 : collide / collide_mask updated from stage-2 layer
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high
//   haddress     horizontal scan position (10 bits)
//   vaddress     vertical scan position (10 bits)
//   spr_en       per-channel enable
//   spr_flip     per-channel horizontal mirror
//   spr_x        packed left edges, channel i at [10i+9:10i]
//   spr_y        packed top edges, same packing
//   wr_en        bitmap row write strobe
//   wr_sel       channel being written
//   wr_row       row being written (values >= SPR_H are ignored)
//   wr_data      row data, MSB = leftmost pixel
//   collide_clr  clears collide and collide_mask (a new collision wins)
//   layer        per-channel opaque bit for the current pixel
//   pixel        OR of layer
//   collide      sticky collision flag
//   collide_mask sticky set of channels involved in collisions
//   frame_done   one-cycle pulse at the end of the active frame
// ---------------------------------------------------------------------------
module sprite_compositor #(
  parameter int NUM_SPR  = 4,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  localparam int SEL_W   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
  localparam int ROW_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            haddress,
  input  logic [9:0]            vaddress,
  input  logic [NUM_SPR-1:0]    spr_en,
  input  logic [NUM_SPR-1:0]    spr_flip,
  input  logic [NUM_SPR*10-1:0] spr_x,
  input  logic [NUM_SPR*10-1:0] spr_y,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [ROW_W-1:0]      wr_row,
  input  logic [SPR_W-1:0]      wr_data,
  input  logic                  collide_clr,
  output logic [NUM_SPR-1:0]    layer,
  output logic                  pixel,
  output logic                  collide,
  output logic [NUM_SPR-1:0]    collide_mask,
  output logic                  frame_done
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;

  localparam logic [10:0]      SPR_W11  = 11'(SPR_W);
  localparam logic [10:0]      SPR_H11  = 11'(SPR_H);
  localparam logic [9:0]       H_ACT10  = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT10  = 10'(V_ACTIVE);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(SPR_W - 1);
  localparam logic [ROW_W:0]   ROW_LIM  = (ROW_W + 1)'(SPR_H);
  localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(NUM_SPR);

  // -------------------------------------------------------------------------
  // Bitmap storage. Deliberately not reset so preloaded contents survive.
  // -------------------------------------------------------------------------
  logic [SPR_W-1:0] bmp [NUM_SPR][SPR_H];

  logic wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_sel} < SEL_LIM);

  always_ff @(posedge clk) begin
    if (wr_ok)
      bmp[wr_sel][wr_row] <= wr_data;
  end

  // -------------------------------------------------------------------------
  // Stage 1: hit test and bitmap coordinates.
  // All compares are done at 11 bits so a sprite near the right/bottom edge
  // produces an end coordinate above 1023 instead of wrapping to column 0.
  // -------------------------------------------------------------------------
  logic [10:0]      h11, v11;
  logic             in_active;
  logic [NUM_SPR-1:0] hit_c;
  logic [COL_W-1:0] col_c [NUM_SPR];
  logic [ROW_W-1:0] row_c [NUM_SPR];

  assign h11       = {1'b0, haddress};
  assign v11       = {1'b0, vaddress};
  assign in_active = (haddress < H_ACT10) && (vaddress < V_ACT10);

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      logic [10:0] x11;
      logic [10:0] y11;
      x11 = {1'b0, spr_x[10*i +: 10]};
      y11 = {1'b0, spr_y[10*i +: 10]};
      hit_c[i] = spr_en[i] && in_active &&
                 (h11 >= x11) && (h11 < x11 + SPR_W11) &&
                 (v11 >= y11) && (v11 < y11 + SPR_H11);
      // Truncated offsets are only meaningful when hit_c[i] is set.
      col_c[i] = COL_W'(h11 - x11);
      row_c[i] = ROW_W'(v11 - y11);
    end
  end

  logic               s1_valid;
  logic [NUM_SPR-1:0] s1_hit;
  logic [NUM_SPR-1:0] s1_flip;
  logic [COL_W-1:0]   s1_col [NUM_SPR];
  logic [ROW_W-1:0]   s1_row [NUM_SPR];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      s1_flip  <= '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        s1_col[i] <= '0;
        s1_row[i] <= '0;
      end
    end else begin
      s1_valid <= 1'b1;
      s1_hit   <= hit_c;
      s1_flip  <= spr_flip;
      for (int i = 0; i < NUM_SPR; i++) begin
        s1_col[i] <= col_c[i];
        s1_row[i] <= row_c[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: bitmap read. Unflipped, column 0 maps to the MSB (leftmost).
  // -------------------------------------------------------------------------
  logic [NUM_SPR-1:0] layer_c;
  logic [COL_W-1:0]   bit_idx [NUM_SPR];
  logic [SPR_W-1:0]   row_word [NUM_SPR];

  always_comb begin
    layer_c = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      bit_idx[i]  = s1_flip[i] ? s1_col[i] : (COL_MAX - s1_col[i]);
      row_word[i] = bmp[i][s1_row[i]];
      layer_c[i]  = s1_valid && s1_hit[i] && row_word[i][bit_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      layer <= '0;
      pixel <= 1'b0;
    end else begin
      layer <= layer_c;
      pixel <= |layer_c;
    end
  end

  // -------------------------------------------------------------------------
  // Collision tracking from the registered layer. layer is forced to zero
  // whenever the pipeline holds no valid pixel, so no separate valid is needed.
  // (x & (x-1)) != 0 exactly when two or more bits are set.
  // -------------------------------------------------------------------------
  logic multi;
  assign multi = |(layer & (layer - NUM_SPR'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      collide      <= 1'b0;
      collide_mask <= '0;
    end else if (multi) begin
      collide      <= 1'b1;
      collide_mask <= collide_clr ? layer : (collide_mask | layer);
    end else if (collide_clr) begin
      collide      <= 1'b0;
      collide_mask <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // End-of-frame pulse: first pixel of the first line past the active area.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      frame_done <= 1'b0;
    else
      frame_done <= (vaddress == V_ACT10) && (haddress == 10'd0);
  end

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  haddress, vaddress;
  logic [3:0]  spr_en, spr_flip;
  logic [39:0] spr_x, spr_y;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [5:0]  wr_row;
  logic [31:0] wr_data;
  logic        collide_clr;
  logic [3:0]  layer;
  logic        pixel;
  logic        collide;
  logic [3:0]  collide_mask;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  sprite_compositor dut (
    .clk(clk), .reset(reset), .haddress(haddress), .vaddress(vaddress),
    .spr_en(spr_en), .spr_flip(spr_flip), .spr_x(spr_x), .spr_y(spr_y),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_data(wr_data),
    .collide_clr(collide_clr), .layer(layer), .pixel(pixel),
    .collide(collide), .collide_mask(collide_mask), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input int sel, input int row, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel[1:0];
    wr_row  = row[5:0];
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic place(input int i, input int x, input int y);
    spr_x[10*i +: 10] = x[9:0];
    spr_y[10*i +: 10] = y[9:0];
  endtask

  task automatic addr(input int h, input int v);
    haddress = h[9:0];
    vaddress = v[9:0];
  endtask

  // Present an address, wait out the two-stage latency, check layer.
  task automatic probe(input string tag, input int h, input int v, input logic [3:0] exp);
    addr(h, v);
    ticks(2);
    chk(tag, layer, exp);
  endtask

  initial begin
    reset = 1'b1; spr_en = '0; spr_flip = '0; spr_x = '0; spr_y = '0;
    wr_en = 1'b0; wr_sel = '0; wr_row = '0; wr_data = '0; collide_clr = 1'b0;
    addr(700, 0);
    ticks(2);
    chk("rst_layer", layer, 4'b0);
    chk("rst_pixel", pixel, 1'b0);
    chk("rst_collide", collide, 1'b0);
    chk("rst_mask", collide_mask, 4'b0);
    chk("rst_fd", frame_done, 1'b0);
    reset = 1'b0;

    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 48; r++) wr(s, r, 32'h0);

    // Single leftmost pixel, normal then mirrored.
    wr(0, 0, 32'h8000_0000);
    wr(0, 60, 32'hFFFF_FFFF);            // out-of-range row: must be dropped
    place(0, 100, 50);
    spr_en = 4'b0001;
    probe("pre_99", 99, 50, 4'b0000);
    addr(100, 50);
    tick();
    chk("lat1_100", layer, 4'b0000);
    tick();
    chk("hit_100", layer, 4'b0001);
    chk("pix_100", pixel, 1'b1);
    probe("blank_101", 101, 50, 4'b0000);
    probe("row1_blank", 100, 51, 4'b0000);
    spr_flip = 4'b0001;
    probe("flip_131", 131, 50, 4'b0001);
    probe("flip_100", 100, 50, 4'b0000);
    chk("flip_pix", pixel, 1'b0);
    spr_flip = 4'b0000;

    // Channels 0 and 2 overlap.
    for (int r = 0; r < 48; r++) begin
      wr(0, r, 32'hFFFF_FFFF);
      wr(2, r, 32'hFFFF_FFFF);
    end
    place(0, 200, 200);
    place(2, 200, 200);
    spr_en = 4'b0101;
    probe("ovl_layer", 200, 200, 4'b0101);
    chk("ovl_not_yet", collide, 1'b0);
    tick();
    chk("ovl_collide", collide, 1'b1);
    chk("ovl_mask", collide_mask, 4'b0101);
    place(2, 400, 200);
    probe("sep_layer", 200, 200, 4'b0001);
    tick();
    chk("sep_sticky", collide, 1'b1);
    chk("sep_mask", collide_mask, 4'b0101);

    // Clear coinciding with a channel 1/3 overlap: set wins.
    for (int r = 0; r < 48; r++) begin
      wr(1, r, 32'hFFFF_FFFF);
      wr(3, r, 32'hFFFF_FFFF);
    end
    place(1, 300, 300);
    place(3, 300, 300);
    spr_en = 4'b1010;
    probe("ovl13_layer", 300, 300, 4'b1010);
    collide_clr = 1'b1;
    tick();
    collide_clr = 1'b0;
    chk("clr_set_collide", collide, 1'b1);
    chk("clr_set_mask", collide_mask, 4'b1010);

    // Plain clear with nothing overlapping.
    spr_en = 4'b0000;
    addr(0, 0);
    ticks(3);
    collide_clr = 1'b1;
    tick();
    collide_clr = 1'b0;
    chk("clr_collide", collide, 1'b0);
    chk("clr_mask", collide_mask, 4'b0000);

    // Right-edge clipping, no wrap onto the start of the line.
    place(0, 630, 100);
    spr_en = 4'b0001;
    for (int v = 100; v <= 101; v++) begin
      for (int h = 628; h < 640; h++)
        probe($sformatf("clip_%0d_%0d", h, v), h, v, (h >= 630) ? 4'b0001 : 4'b0000);
      for (int h = 0; h < 22; h++)
        probe($sformatf("wrap_%0d_%0d", h, v), h, v, 4'b0000);
    end

    // End-of-frame pulse.
    addr(0, 479);
    tick();
    chk("fd_479", frame_done, 1'b0);
    addr(0, 480);
    tick();
    chk("fd_480", frame_done, 1'b1);
    addr(1, 480);
    tick();
    chk("fd_off", frame_done, 1'b0);

    // Reset mid-frame with a collision pending.
    spr_en = 4'b1010;
    probe("pre_rst_layer", 300, 300, 4'b1010);
    tick();
    chk("pre_rst_collide", collide, 1'b1);
    reset = 1'b1;
    spr_en = 4'b0001;
    addr(635, 100);
    tick();
    chk("mid_rst_layer", layer, 4'b0);
    chk("mid_rst_pixel", pixel, 1'b0);
    chk("mid_rst_collide", collide, 1'b0);
    chk("mid_rst_mask", collide_mask, 4'b0);
    chk("mid_rst_fd", frame_done, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_lat1", layer, 4'b0000);
    tick();
    chk("post_rst_ch0", layer, 4'b0001);
    spr_en = 4'b1000;
    probe("post_rst_ch3", 301, 301, 4'b1000);
    chk("post_rst_collide", collide, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
